seq_approx_divider: RTL and testbench
=====================================

Name: seq_approx_divider

Overview:
- Iterative restoring divider, N_W/D_W unsigned. Produces one quotient bit per clock through a single row of D_W subtractor cells, instead of a fully unrolled array.
- The lowest APPROX_COLS cells of the row use the approximate subtractor cell; the upper cells are exact.
- Valid/ready on input and output. Sits in the approximate-arithmetic datapath library as the area-optimised counterpart of the combinational array dividers.

Parameters:
- N_W, 16, dividend width; must satisfy N_W > D_W.
- D_W, 8, divisor and remainder width.
- Q_W, N_W-D_W, quotient width and iteration count (derived, localparam).
- APPROX_COLS, 6, number of low-order cells (columns 0..APPROX_COLS-1) built as approximate cells; range 0..D_W.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- n  input  N_W  dividend
- d  input  D_W  divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- q  output  Q_W  quotient
- r  output  D_W  remainder

Behaviour:
- Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; q=0; r=0; all internal registers 0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch d and n[Q_W-1:0], set R=n[N_W-1:Q_W], i=Q_W-1, go to BUSY.
  - BUSY: in_ready=0; one iteration per cycle. After the step with i=0, go to DONE.
  - DONE: out_valid=1; q and r held stable. On out_ready, go to IDLE with out_valid=0 that cycle.
- Iteration step i:
  - ovf=R[D_W-1]; M={R[D_W-2:0],n[i]}.
  - Ripple-borrow chain over columns 0..D_W-1 with x=M[k], y=d[k], bin(0)=0.
  - qbit=ovf | ~bout(D_W-1). R_next[k] = qbit ? diff[k] : M[k]. q[i]=qbit.
- Exact cell: diff=x^y^bin; bout=(~x&y) | (~(x^y)&bin).
- Approximate cell: diff=x|bin; bout=~bin (y ignored).
- Latency: accepting edge, then Q_W BUSY edges; out_valid high from the cycle after the last iteration. Total Q_W+1 cycles from accept to out_valid, with no out backpressure.
- Throughput: one operation per Q_W+2 cycles minimum. in_ready=0 in BUSY and DONE (no overlap).
- r=R after the final step. q is built MSB first into a Q_W register.
- With APPROX_COLS=0 and n[N_W-1:Q_W] < d: q=floor(n/d), r=n mod d, bit-exact.
- Quotient overflow (n[N_W-1:Q_W] >= d, d != 0): no error. Result is whatever the step equations produce, identical to the combinational array of the same cell mix.
- d=0: no special-casing. With exact cells every qbit=1, so q=all ones and r=n[D_W-1:0].
- in_valid while in_ready=0: ignored; operands are not captured.
- out_ready held high in DONE: handshake completes in one cycle.
- Reset mid-operation: operation discarded, block returns to IDLE; no out_valid is produced for it.

Optional Feature:
- Macro: SEQ_DIV_DIV0_FLAG_EN.
- Defined: adds output div0 (1 bit).
  - Registered at accept as (d==0) and valid alongside out_valid; reset value 0.
  - When div0=1, q is forced to all ones and r to n[D_W-1:0] regardless of APPROX_COLS.
  - The FSM skips BUSY: result is presented in DONE on the cycle after accept.
- Undefined: no div0 port. d=0 follows the normal iteration path, including any approximate-cell effects.

Decomposition:
- Shared package div_pkg: state enum (IDLE, BUSY, DONE); function cell_is_approx(col, APPROX_COLS); exact-cell and approximate-cell equation functions. The bench reference model reuses these functions.
- One sub-module, div_sub_cell: parameter APPROX (0/1); ports x, y, bin, qs, r_sub, bout; same mux semantics as the array cells. Instantiated D_W times by generate.

Test Plan:
- Exact, APPROX_COLS=0, n=1000, d=7 -> after 9 cycles q=142, r=6; in_ready low for 9 cycles.
- Exact, n=0x00FF, d=0xFF -> q=1, r=0; n=0x0000, d=5 -> q=0, r=0.
- d=0, n=0x1234, macro off, exact -> q=0xFF, r=0x34. Macro on -> same q/r, div0=1, out_valid on cycle 2.
- Backpressure: out_ready low for 5 cycles in DONE -> q/r stable, in_ready=0; a new in_valid is ignored until handshake. Back-to-back ops are then accepted in order.
- Reset asserted at BUSY iteration 3 -> out_valid=0, q=r=0 immediately; next op completes correctly.
- APPROX_COLS=6, 2000 random (n,d) with d>n[15:8] -> q/r bit-exact against the div_pkg step model; APPROX_COLS=D_W also checked.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and cell equations for the sequential approximate divider.
// Cell functions return {bout, diff}.
package div_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic bit cell_is_approx(input int col, input int approx_cols);
    return col < approx_cols;
  endfunction

  function automatic logic [1:0] exact_cell(input logic x, input logic y, input logic bin);
    logic diff, bout;
    diff = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
    return {bout, diff};
  endfunction

  // Divisor bit is ignored entirely in the approximate cell.
  function automatic logic [1:0] approx_cell(input logic x, input logic bin);
    logic diff, bout;
    diff = x | bin;
    bout = ~bin;
    return {bout, diff};
  endfunction
endpackage

// File: rtl/div_sub_cell.sv
// One column of the subtract/restore row: borrow-ripple subtractor cell
// followed by the restore mux selected by the row's quotient bit.
module div_sub_cell
  import div_pkg::*;
#(
  parameter bit APPROX = 1'b0
) (
  input  logic x,
  input  logic y,
  input  logic bin,
  input  logic qs,
  output logic r_sub,
  output logic bout
);
  logic [1:0] ex, ap, sel;

  assign ex    = exact_cell(x, y, bin);
  assign ap    = approx_cell(x, bin);
  assign sel   = APPROX ? ap : ex;
  assign bout  = sel[1];
  assign r_sub = qs ? sel[0] : x;
endmodule

// File: rtl/seq_approx_divider.sv
// Iterative restoring divider, one quotient bit per clock through a single
// row of D_W cells. Optional div0 flag and BUSY bypass: SEQ_DIV_DIV0_FLAG_EN.
module seq_approx_divider
  import div_pkg::*;
#(
  parameter int N_W         = 16,
  parameter int D_W         = 8,
  parameter int APPROX_COLS = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_W-1:0]     n,
  input  logic [D_W-1:0]     d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_W-D_W-1:0] q,
  output logic [D_W-1:0]     r
`ifdef SEQ_DIV_DIV0_FLAG_EN
  ,
  output logic               div0
`endif
);
  localparam int Q_W = N_W - D_W;
  localparam int I_W = (Q_W > 1) ? $clog2(Q_W) : 1;

  state_t         state;
  logic [D_W-1:0] d_r;
  logic [Q_W-1:0] n_lo;
  logic [I_W-1:0] i_r;

  logic           ovf, qbit;
  logic [D_W-1:0] m, r_next;
  logic [D_W:0]   b;

  // r doubles as the partial remainder register between iterations.
  assign ovf  = r[D_W-1];
  assign m    = {r[D_W-2:0], n_lo[i_r]};
  assign b[0] = 1'b0;
  assign qbit = ovf | ~b[D_W];

  for (genvar k = 0; k < D_W; k++) begin : g_col
    div_sub_cell #(
      .APPROX(cell_is_approx(k, APPROX_COLS))
    ) u_cell (
      .x    (m[k]),
      .y    (d_r[k]),
      .bin  (b[k]),
      .qs   (qbit),
      .r_sub(r_next[k]),
      .bout (b[k+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      q         <= '0;
      r         <= '0;
      d_r       <= '0;
      n_lo      <= '0;
      i_r       <= '0;
`ifdef SEQ_DIV_DIV0_FLAG_EN
      div0      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_r      <= d;
            n_lo     <= n[Q_W-1:0];
            r        <= n[N_W-1:Q_W];
            q        <= '0;
            i_r      <= I_W'(Q_W - 1);
            in_ready <= 1'b0;
            state    <= BUSY;
`ifdef SEQ_DIV_DIV0_FLAG_EN
            div0     <= (d == '0);
            if (d == '0) begin
              q         <= '1;
              r         <= n[D_W-1:0];
              out_valid <= 1'b1;
              state     <= DONE;
            end
`endif
          end
        end
        BUSY: begin
          r      <= r_next;
          q[i_r] <= qbit;
          i_r    <= i_r - 1'b1;
          if (i_r == '0) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_approx_divider.sv
// Directed bench for seq_approx_divider: exact, APPROX_COLS=6 and
// APPROX_COLS=D_W instances driven in lockstep from one stimulus stream.
module tb_seq_approx_divider;
  import div_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [15:0] n_i = '0;
  logic [7:0]  d_i = '0;

  logic       ir [3];
  logic       ov [3];
  logic [7:0] q_o [3];
  logic [7:0] r_o [3];
  logic       dz [3];

  int checks = 0;
  int failures = 0;
  int ac_tab [3] = '{0, 6, 8};

  always #5 clk = ~clk;

`ifdef SEQ_DIV_DIV0_FLAG_EN
  `define DZ_PORT(j) , .div0(dz[j])
`else
  `define DZ_PORT(j)
  initial begin dz[0] = 1'b0; dz[1] = 1'b0; dz[2] = 1'b0; end
`endif

  seq_approx_divider #(.N_W(16), .D_W(8), .APPROX_COLS(0)) u_ex (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .n(n_i), .d(d_i),
    .out_valid(ov[0]), .out_ready(out_ready), .q(q_o[0]), .r(r_o[0]) `DZ_PORT(0));
  seq_approx_divider #(.N_W(16), .D_W(8), .APPROX_COLS(6)) u_ap6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .n(n_i), .d(d_i),
    .out_valid(ov[1]), .out_ready(out_ready), .q(q_o[1]), .r(r_o[1]) `DZ_PORT(1));
  seq_approx_divider #(.N_W(16), .D_W(8), .APPROX_COLS(8)) u_ap8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .n(n_i), .d(d_i),
    .out_valid(ov[2]), .out_ready(out_ready), .q(q_o[2]), .r(r_o[2]) `DZ_PORT(2));

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d;
    logic [7:0]  eq;
    logic [7:0]  er;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Step model built from the shared cell equations; returns {q, r}.
  function automatic logic [15:0] model(input logic [15:0] nn, input logic [7:0] dd, input int ac);
    logic [7:0] rr, m, nx, qq;
    logic       b, ovf, qb;
    logic [1:0] c;
`ifdef SEQ_DIV_DIV0_FLAG_EN
    if (dd == 0) return {8'hFF, nn[7:0]};
`endif
    rr = nn[15:8];
    qq = '0;
    for (int i = 7; i >= 0; i--) begin
      ovf = rr[7];
      m   = {rr[6:0], nn[i]};
      b   = 1'b0;
      for (int k = 0; k < 8; k++) begin
        c = cell_is_approx(k, ac) ? approx_cell(m[k], b) : exact_cell(m[k], dd[k], b);
        nx[k] = c[0];
        b     = c[1];
      end
      qb    = ovf | ~b;
      qq[i] = qb;
      rr    = qb ? nx : m;
    end
    return {qq, rr};
  endfunction

  function automatic int exp_lat(input logic [7:0] dd);
`ifdef SEQ_DIV_DIV0_FLAG_EN
    if (dd == 0) return 0;
`endif
    return 8;
  endfunction

  // Issue one op; checks latency, busy in_ready, results of all instances and,
  // if out_ready is high, the single-cycle handshake.
  task automatic run_op(input string nm, input logic [15:0] nn, input logic [7:0] dd,
                        input bit has_exp, input logic [7:0] eq, input logic [7:0] er);
    int cnt;
    logic [15:0] e;
    check({nm, "_in_ready"}, int'(ir[0]), 1);
    n_i = nn; d_i = dd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!ov[0] && cnt < 40) begin
      check({nm, "_busy_in_ready"}, int'(ir[0]), 0);
      @(posedge clk); #1;
      cnt++;
    end
    check({nm, "_latency"}, cnt, exp_lat(dd));
    check({nm, "_done_in_ready"}, int'(ir[0]), 0);
    if (has_exp) begin
      check({nm, "_q_exact"}, int'(q_o[0]), int'(eq));
      check({nm, "_r_exact"}, int'(r_o[0]), int'(er));
    end
    for (int j = 0; j < 3; j++) begin
      e = model(nn, dd, ac_tab[j]);
      check($sformatf("%s_ov%0d", nm, j), int'(ov[j]), 1);
      check($sformatf("%s_q%0d", nm, j), int'(q_o[j]), int'(e[15:8]));
      check($sformatf("%s_r%0d", nm, j), int'(r_o[j]), int'(e[7:0]));
`ifdef SEQ_DIV_DIV0_FLAG_EN
      check($sformatf("%s_div0_%0d", nm, j), int'(dz[j]), int'(dd == 0));
`endif
    end
    if (out_ready) begin
      @(posedge clk); #1;
      check({nm, "_ov_drop"}, int'(ov[0]), 0);
      check({nm, "_in_ready_back"}, int'(ir[0]), 1);
    end
  endtask

  vec_t vt [7];
  logic [15:0] e6;

  initial begin
    vt[0] = '{16'd1000,  8'd7,   8'd142,  8'd6};
    vt[1] = '{16'h00FF,  8'hFF,  8'd1,    8'd0};
    vt[2] = '{16'h0000,  8'd5,   8'd0,    8'd0};
    vt[3] = '{16'h1234,  8'd0,   8'hFF,   8'h34};
    vt[4] = '{16'h0A00,  8'd11,  8'd232,  8'd8};
    vt[5] = '{16'h7FFF,  8'hFF,  8'd128,  8'd127};
    vt[6] = '{16'd100,   8'd3,   8'd33,   8'd1};

    #12;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("rst_in_ready%0d", j), int'(ir[j]), 1);
      check($sformatf("rst_ov%0d", j), int'(ov[j]), 0);
      check($sformatf("rst_q%0d", j), int'(q_o[j]), 0);
      check($sformatf("rst_r%0d", j), int'(r_o[j]), 0);
      check($sformatf("rst_dz%0d", j), int'(dz[j]), 0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vt[i].n, vt[i].d, 1'b1, vt[i].eq, vt[i].er);

    // Backpressure: result held 5 cycles, stray in_valid ignored.
    out_ready = 1'b0;
    run_op("bp", 16'd1000, 8'd7, 1'b1, 8'd142, 8'd6);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin n_i = 16'h0505; d_i = 8'd3; in_valid = 1'b1; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      e6 = model(16'd1000, 8'd7, 6);
      check($sformatf("bp_hold_ov_c%0d", c), int'(ov[0]), 1);
      check($sformatf("bp_hold_q_c%0d", c), int'(q_o[0]), 142);
      check($sformatf("bp_hold_r_c%0d", c), int'(r_o[0]), 6);
      check($sformatf("bp_hold_q6_c%0d", c), int'(q_o[1]), int'(e6[15:8]));
      check($sformatf("bp_hold_rdy_c%0d", c), int'(ir[0]), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ov", int'(ov[0]), 0);
    check("bp_release_rdy", int'(ir[0]), 1);
    @(posedge clk); #1;
    check("bp_not_captured_rdy", int'(ir[0]), 1);
    check("bp_not_captured_ov", int'(ov[0]), 0);
    run_op("b2b_a", 16'd500, 8'd9, 1'b1, 8'd55, 8'd5);
    run_op("b2b_b", 16'd60000, 8'd250, 1'b1, 8'd240, 8'd0);

    // Reset during the third BUSY iteration.
    n_i = 16'd1000; d_i = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ov", int'(ov[0]), 0);
    check("mid_rst_q", int'(q_o[0]), 0);
    check("mid_rst_r", int'(r_o[0]), 0);
    check("mid_rst_rdy", int'(ir[0]), 1);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("mid_rst_no_ov", int'(ov[0]), 0);
    end
    run_op("post_rst", 16'd1000, 8'd7, 1'b1, 8'd142, 8'd6);

    // Random in-range operands; approximate instances against the step model.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] rn;
      logic [7:0]  rd;
      logic [7:0]  hi;
      hi = 8'($urandom_range(0, 254));
      rd = 8'($urandom_range(int'(hi) + 1, 255));
      rn = {hi, 8'($urandom_range(0, 255))};
      run_op("rnd", rn, rd, 1'b1, 8'(rn / rd), 8'(rn % rd));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
